// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: assembles LANE_WIDTH-bit beats into a shadow register and commits CFG_SIZE bits atomically.
// Commit is visible one cycle after the final beat; StreamReady drops outside LOAD/CHECK and whenever StreamStart is high. CFG_LOADER_PARITY_EN adds an XOR check beat.
module cfg_stream_loader #(
  parameter int CFG_SIZE   = 100,
  parameter int LANE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StreamStart,
  input  logic [LANE_WIDTH-1:0] SerialIn,
  input  logic                  StreamValid,
  output logic                  StreamReady,
  output logic [CFG_SIZE-1:0]   ParallelOut,
  output logic                  CfgDone,
  output logic                  CfgUpdate,
  output logic                  CfgError
);

  localparam int N_BEATS = (CFG_SIZE + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int SH_W    = N_BEATS * LANE_WIDTH;
  localparam int CNT_W   = $clog2(N_BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef CFG_LOADER_PARITY_EN
    S_CHECK = 3'd2,
`endif
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [SH_W-1:0]     shadow;
  logic [SH_W-1:0]     shadow_nxt;
  logic                accept;
  logic                last_data;
  logic                commit_en;
  logic [CFG_SIZE-1:0] commit_val;

`ifdef CFG_LOADER_PARITY_EN
  logic [LANE_WIDTH-1:0] parity;
  logic                  check_ok;
`endif

  assign accept     = StreamValid && StreamReady;
  assign last_data  = (state == S_LOAD) && accept && (cnt == CNT_W'(N_BEATS - 1));
  // Older beats shift toward the MSBs, so the first beat's PAD bits fall off at commit.
  assign shadow_nxt = SH_W'({shadow, SerialIn});

`ifdef CFG_LOADER_PARITY_EN
  assign check_ok   = (SerialIn == parity);
  assign commit_en  = (state == S_CHECK) && accept && check_ok;
  assign commit_val = CFG_SIZE'(shadow);
`else
  assign commit_en  = last_data;
  assign commit_val = CFG_SIZE'(shadow_nxt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (StreamStart) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          if (last_data) begin
`ifdef CFG_LOADER_PARITY_EN
            state_nxt = S_CHECK;
`else
            state_nxt = S_DONE;
`endif
          end
        end
`ifdef CFG_LOADER_PARITY_EN
        S_CHECK: begin
          if (accept) begin
            state_nxt = check_ok ? S_DONE : S_ERROR;
          end
        end
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    StreamReady = 1'b0;
    CfgDone     = 1'b0;
    CfgError    = 1'b0;
`ifdef CFG_LOADER_PARITY_EN
    StreamReady = ((state == S_LOAD) || (state == S_CHECK)) && !StreamStart;
    CfgError    = (state == S_ERROR);
`else
    StreamReady = (state == S_LOAD) && !StreamStart;
`endif
    CfgDone     = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      shadow      <= '0;
      ParallelOut <= '0;
      CfgUpdate   <= 1'b0;
`ifdef CFG_LOADER_PARITY_EN
      parity      <= '0;
`endif
    end else begin
      CfgUpdate <= commit_en;
      if (commit_en) begin
        ParallelOut <= commit_val;
      end
      if (StreamStart) begin
        cnt <= '0;
`ifdef CFG_LOADER_PARITY_EN
        parity <= '0;
`endif
      end else if ((state == S_LOAD) && accept) begin
        shadow <= shadow_nxt;
        cnt    <= cnt + CNT_W'(1);
`ifdef CFG_LOADER_PARITY_EN
        parity <= parity ^ SerialIn;
`endif
      end
    end
  end

  cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_W'(N_BEATS));

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Bench for cfg_stream_loader: 10-bit/4-lane instance against a queue-based model, plus a 100-bit/8-lane random frame.
module tb_cfg_stream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_start, a_valid, a_ready, a_done, a_upd, a_err;
  logic [3:0] a_data;
  logic [9:0] a_out;

  logic        b_start, b_valid, b_ready, b_done, b_upd, b_err;
  logic [7:0]  b_data;
  logic [99:0] b_out;

  cfg_stream_loader #(.CFG_SIZE(10), .LANE_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .StreamStart(a_start), .SerialIn(a_data), .StreamValid(a_valid),
    .StreamReady(a_ready), .ParallelOut(a_out), .CfgDone(a_done), .CfgUpdate(a_upd), .CfgError(a_err)
  );

  cfg_stream_loader #(.CFG_SIZE(100), .LANE_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .StreamStart(b_start), .SerialIn(b_data), .StreamValid(b_valid),
    .StreamReady(b_ready), .ParallelOut(b_out), .CfgDone(b_done), .CfgUpdate(b_upd), .CfgError(b_err)
  );

`ifdef CFG_LOADER_PARITY_EN
  localparam int FRAME = 4;
`else
  localparam int FRAME = 3;
`endif

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just the list of beats accepted since the last start.
  logic       m_loading = 1'b0;
  logic [3:0] m_q[$];
  logic [9:0] m_out = '0;
  logic       m_done = 1'b0, m_err = 1'b0, m_upd = 1'b0;
  logic [15:0] m_v;
  logic       m_ok;

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 1'b0; m_q.delete(); m_out = '0; m_done = 1'b0; m_err = 1'b0; m_upd = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (a_start) begin
        m_loading = 1'b1; m_q.delete(); m_done = 1'b0; m_err = 1'b0;
      end else if (m_loading && a_valid) begin
        m_q.push_back(a_data);
        if (m_q.size() == FRAME) begin
          m_v = '0;
          for (int i = 0; i < 3; i++) m_v = (m_v << 4) | {12'd0, m_q[i]};
          m_ok = 1'b1;
`ifdef CFG_LOADER_PARITY_EN
          m_ok = (m_q[3] == (m_q[0] ^ m_q[1] ^ m_q[2]));
`endif
          m_loading = 1'b0;
          if (m_ok) begin
            m_out = m_v[9:0]; m_done = 1'b1; m_upd = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", {127'd0, a_ready}, {127'd0, m_loading && !a_start});
    chk("out",   {118'd0, a_out},   {118'd0, m_out});
    chk("done",  {127'd0, a_done},  {127'd0, m_done});
    chk("upd",   {127'd0, a_upd},   {127'd0, m_upd});
    chk("err",   {127'd0, a_err},   {127'd0, m_err});
    if (a_upd) upd_cnt++;
  end

  task automatic drive(input logic s, input logic v, input logic [3:0] d);
    a_start = s; a_valid = v; a_data = d;
    @(posedge clk); #2;
  endtask

  task automatic send_beats(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2);
    drive(1'b0, 1'b1, b0);
    drive(1'b0, 1'b1, b1);
    drive(1'b0, 1'b1, b2);
`ifdef CFG_LOADER_PARITY_EN
    drive(1'b0, 1'b1, b0 ^ b1 ^ b2);
`endif
    a_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2);
    drive(1'b1, 1'b0, 4'h0);
    send_beats(b0, b1, b2);
  endtask

  task automatic drive_b(input logic s, input logic v, input logic [7:0] d);
    b_start = s; b_valid = v; b_data = d;
    @(posedge clk); #2;
  endtask

  int cnt0;
  int nb;
  logic [127:0] b_acc;
  logic [7:0]   b_par;
  logic [7:0]   b_byte;

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_out", {118'd0, a_out}, 128'd0);
    chk("rst_ready", {127'd0, a_ready}, 128'd0);
    chk("rst_b_out", {28'd0, b_out}, 128'd0);
    rst = 1'b0;

    // 1: basic frame
    send_frame(4'h1, 4'h2, 4'h3);
    chk("t1_out", {118'd0, a_out}, 128'h123);
    chk("t1_model", {118'd0, m_out}, 128'h123);
    chk("t1_upd", {127'd0, a_upd}, 128'd1);
    chk("t1_done", {127'd0, a_done}, 128'd1);
    drive(1'b0, 1'b0, 4'h0);
    chk("t1_upd_drop", {127'd0, a_upd}, 128'd0);

    // 2: PAD bits of the first beat dropped, then aborted reload
    send_frame(4'hF, 4'h0, 4'h0);
    chk("t2_out", {118'd0, a_out}, 128'h300);
    drive(1'b0, 1'b0, 4'h0);
    cnt0 = upd_cnt;
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'h7);
    drive(1'b0, 1'b1, 4'h8);
    drive(1'b1, 1'b0, 4'h0);
    chk("t2_abort_out", {118'd0, a_out}, 128'h300);
    chk("t2_abort_done", {127'd0, a_done}, 128'd0);
    chk("t2_no_pulse", upd_cnt, cnt0);

    // 3: start beats a simultaneous valid beat
    a_start = 1'b1; a_valid = 1'b1; a_data = 4'hA;
    #1;
    chk("t3_ready", {127'd0, a_ready}, 128'd0);
    @(posedge clk); #2;
    send_beats(4'h4, 4'h5, 4'h6);
    chk("t3_out", {118'd0, a_out}, 128'h056);
    chk("t3_model", {118'd0, m_out}, 128'h056);

    // 4: bubbles, then beats offered while done
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'h9);
    nb = $urandom_range(1, 3);
    repeat (nb) drive(1'b0, 1'b0, 4'hF);
    drive(1'b0, 1'b1, 4'hC);
    nb = $urandom_range(1, 3);
    repeat (nb) drive(1'b0, 1'b0, 4'hF);
    chk("t4_wait_out", {118'd0, a_out}, 128'h056);
    chk("t4_wait_done", {127'd0, a_done}, 128'd0);
    drive(1'b0, 1'b1, 4'hD);
`ifdef CFG_LOADER_PARITY_EN
    drive(1'b0, 1'b0, 4'hF);
    drive(1'b0, 1'b1, 4'h8);
`endif
    a_valid = 1'b0;
    chk("t4_out", {118'd0, a_out}, 128'h1CD);
    chk("t4_done", {127'd0, a_done}, 128'd1);
    drive(1'b0, 1'b0, 4'h0);
    cnt0 = upd_cnt;
    drive(1'b0, 1'b1, 4'h1);
    drive(1'b0, 1'b1, 4'h2);
    drive(1'b0, 1'b0, 4'h0);
    chk("t4_post_out", {118'd0, a_out}, 128'h1CD);
    chk("t4_post_done", {127'd0, a_done}, 128'd1);
    chk("t4_post_pulse", upd_cnt, cnt0);

`ifdef CFG_LOADER_PARITY_EN
    // 5: check beat good, then bad
    send_frame(4'h1, 4'h2, 4'h3);
    chk("t5_out", {118'd0, a_out}, 128'h123);
    drive(1'b0, 1'b0, 4'h0);
    cnt0 = upd_cnt;
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'h1);
    drive(1'b0, 1'b1, 4'h2);
    drive(1'b0, 1'b1, 4'h3);
    drive(1'b0, 1'b1, 4'h5);
    a_valid = 1'b0;
    chk("t5_err", {127'd0, a_err}, 128'd1);
    chk("t5_err_done", {127'd0, a_done}, 128'd0);
    chk("t5_err_out", {118'd0, a_out}, 128'h123);
    drive(1'b0, 1'b0, 4'h0);
    chk("t5_no_pulse", upd_cnt, cnt0);
`endif

    // 6: reset mid-frame, then a clean frame
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'h3);
    drive(1'b0, 1'b1, 4'h4);
    rst = 1'b1; a_valid = 1'b0;
    @(posedge clk); #2;
    chk("t6_rst_out", {118'd0, a_out}, 128'd0);
    chk("t6_rst_done", {127'd0, a_done}, 128'd0);
    chk("t6_rst_ready", {127'd0, a_ready}, 128'd0);
    rst = 1'b0;
    send_frame(4'hA, 4'hB, 4'hC);
    chk("t6_out", {118'd0, a_out}, 128'h2BC);
    chk("t6_done", {127'd0, a_done}, 128'd1);

    // Wide instance: 13 random bytes, PAD of 4 bits
    drive_b(1'b1, 1'b0, 8'h00);
    b_acc = '0; b_par = '0;
    for (int i = 0; i < 13; i++) begin
      b_byte = 8'($urandom);
      b_acc = (b_acc << 8) | {120'd0, b_byte};
      b_par = b_par ^ b_byte;
      drive_b(1'b0, 1'b1, b_byte);
    end
`ifdef CFG_LOADER_PARITY_EN
    drive_b(1'b0, 1'b1, b_par);
`endif
    b_valid = 1'b0;
    chk("b_out", {28'd0, b_out}, {28'd0, b_acc[99:0]});
    chk("b_upd", {127'd0, b_upd}, 128'd1);
    chk("b_done", {127'd0, b_done}, 128'd1);
    chk("b_err", {127'd0, b_err}, 128'd0);
    drive_b(1'b0, 1'b0, 8'h00);
    chk("b_upd_drop", {127'd0, b_upd}, 128'd0);
    chk("b_ready_done", {127'd0, b_ready}, 128'd0);

    drive(1'b0, 1'b0, 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
